// File: rtl/vga_fb_pkg.sv
// Shared definitions for the VGA framebuffer streamer: FSM encoding, data_out bit map, frame totals.
// Pure declarations; no logic, no latency.
package vga_fb_pkg;

  typedef enum logic [1:0] {
    ST_READ      = 2'd0,
    ST_ENTER     = 2'd1,
    ST_WR_IDLE   = 2'd2,
    ST_WR_STROBE = 2'd3
  } fb_state_e;

  localparam int DO_WRITE_BIT  = 7;
  localparam int DO_RESET_PTR  = 6;
  localparam int DO_STROBE     = 5;
  localparam int DO_NIBBLE_LSB = 0;
  localparam int DO_NIBBLE_W   = 4;

  function automatic int h_total(input int vis, input int fp, input int sp, input int bp);
    return vis + fp + sp + bp;
  endfunction

  function automatic int v_total(input int vis, input int fp, input int sp, input int bp);
    return vis + fp + sp + bp;
  endfunction

endpackage

// File: rtl/vga_fb_wr_fifo.sv
// Generic synchronous FIFO; pop_dat shows the head combinationally, push/pop take effect on the clock edge.
// push_rdy drops when full; a push offered while full is ignored here and flagged by the caller.
module vga_fb_wr_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  output logic                   push_rdy,
  input  logic                   pop_rdy,
  output logic                   pop_vld,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign push_rdy = (level_q != LW'(DEPTH));
  assign pop_vld  = (level_q != '0);
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop_rdy && pop_vld;
  assign pop_dat  = mem_q[rd_ptr_q];
  assign level    = level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through the reset pointers/level.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/vga_fb_streamer.sv
// VGA timing generator streaming pixels from QSPI RAM, with queued pixel writes issued during vblank.
// Sync/frame_start/data_out are registered from next-state counters; wr_ready drops when the queue is full.
module vga_fb_streamer
  import vga_fb_pkg::*;
#(
  parameter int   LINE_VISIBLE     = 640,
  parameter int   LINE_FRONT_PORCH = 16,
  parameter int   LINE_SYNC_PULSE  = 96,
  parameter int   LINE_BACK_PORCH  = 48,
  parameter int   ROW_VISIBLE      = 480,
  parameter int   ROW_FRONT_PORCH  = 10,
  parameter int   ROW_SYNC_PULSE   = 2,
  parameter int   ROW_BACK_PORCH   = 33,
  parameter int   PIXEL_BITS       = 4,
  parameter logic SYNC_ACTIVE      = 1'b1,
  parameter int   FIFO_DEPTH       = 8,
  parameter int   WAIT_CYCLES      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        h_sync,
  output logic                        v_sync,
  output logic [PIXEL_BITS-1:0]       pixel_out,
  output logic                        frame_start,
  output logic [7:0]                  data_dir,
  input  logic [7:0]                  data_in,
  output logic [7:0]                  data_out,
  input  logic                        wr_valid,
  input  logic [PIXEL_BITS-1:0]       wr_data,
  input  logic                        wr_ptr_reset,
  output logic                        wr_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);
  localparam int H_TOTAL  = h_total(LINE_VISIBLE, LINE_FRONT_PORCH, LINE_SYNC_PULSE, LINE_BACK_PORCH);
  localparam int V_TOTAL  = v_total(ROW_VISIBLE, ROW_FRONT_PORCH, ROW_SYNC_PULSE, ROW_BACK_PORCH);
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int QW       = PIXEL_BITS + 1;
  localparam int HS_START = LINE_VISIBLE + LINE_FRONT_PORCH;
  localparam int HS_END   = HS_START + LINE_SYNC_PULSE;
  localparam int VS_START = ROW_VISIBLE + ROW_FRONT_PORCH;
  localparam int VS_END   = VS_START + ROW_SYNC_PULSE;

  logic [HW-1:0]         pix_q, pix_d;
  logic [VW-1:0]         line_q, line_d;
  logic                  h_sync_q, v_sync_q, frame_start_q, overflow_q;
  logic [PIXEL_BITS-1:0] pix_reg_q;
  fb_state_e             state_q;
  logic [3:0]            cnt_q, nibble_q;
  logic                  write_bit_q, write_dir_q, strobe_q, reset_ptr_q;
  logic                  vblank_d, last_line_d, visible;
  logic                  q_push_rdy, q_pop_rdy, q_pop_vld;
  logic [QW-1:0]         q_pop_dat;
  logic                  unused_data_in;

  always_comb begin
    pix_d  = pix_q + 1'b1;
    line_d = line_q;
    if (int'(pix_q) == H_TOTAL - 1) begin
      pix_d  = '0;
      line_d = (int'(line_q) == V_TOTAL - 1) ? '0 : line_q + 1'b1;
    end
  end

  // FSM decisions look at the line of the coming cycle so write_bit edges land on pixel 0.
  assign vblank_d    = (int'(line_d) >= ROW_VISIBLE);
  assign last_line_d = (int'(line_d) == V_TOTAL - 1);
  assign visible     = (int'(pix_q) < LINE_VISIBLE) && (int'(line_q) < ROW_VISIBLE);
  assign q_pop_rdy   = (state_q == ST_WR_IDLE) && !last_line_d;

  vga_fb_wr_fifo #(.WIDTH(QW), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (wr_valid),
    .push_dat ({wr_ptr_reset, wr_data}),
    .push_rdy (q_push_rdy),
    .pop_rdy  (q_pop_rdy),
    .pop_vld  (q_pop_vld),
    .pop_dat  (q_pop_dat),
    .level    (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_q         <= '0;
      line_q        <= '0;
      h_sync_q      <= ~SYNC_ACTIVE;
      v_sync_q      <= ~SYNC_ACTIVE;
      frame_start_q <= 1'b0;
      pix_reg_q     <= '0;
      overflow_q    <= 1'b0;
    end else begin
      pix_q         <= pix_d;
      line_q        <= line_d;
      h_sync_q      <= (int'(pix_d) >= HS_START && int'(pix_d) < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      v_sync_q      <= (int'(line_d) >= VS_START && int'(line_d) < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      frame_start_q <= (pix_d == '0) && (line_d == '0);
      if (state_q == ST_READ) pix_reg_q <= data_in[PIXEL_BITS-1:0];
      if (wr_valid && !q_push_rdy) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_READ;
      cnt_q       <= '0;
      write_bit_q <= 1'b0;
      write_dir_q <= 1'b0;
      strobe_q    <= 1'b0;
      nibble_q    <= '0;
      reset_ptr_q <= 1'b0;
    end else begin
      strobe_q    <= 1'b0;
      nibble_q    <= '0;
      reset_ptr_q <= 1'b0;
      case (state_q)
        ST_READ: begin
          if (vblank_d && q_pop_vld && !last_line_d) begin
            state_q     <= ST_ENTER;
            write_bit_q <= 1'b1;
            cnt_q       <= '0;
          end
        end
        ST_ENTER: begin
          if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
            state_q     <= ST_WR_IDLE;
            write_dir_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WR_IDLE: begin
          if (!q_pop_vld || last_line_d) begin
            state_q     <= ST_READ;
            write_bit_q <= 1'b0;
            write_dir_q <= 1'b0;
          end else begin
            state_q     <= ST_WR_STROBE;
            strobe_q    <= 1'b1;
            nibble_q    <= 4'(q_pop_dat[PIXEL_BITS-1:0]);
            reset_ptr_q <= q_pop_dat[PIXEL_BITS];
          end
        end
        ST_WR_STROBE: state_q <= ST_WR_IDLE;
        default:      state_q <= ST_READ;
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    data_out[DO_WRITE_BIT] = write_bit_q;
    data_out[DO_RESET_PTR] = (state_q == ST_READ || state_q == ST_ENTER) ?
                             (h_sync_q == SYNC_ACTIVE) : reset_ptr_q;
    data_out[DO_STROBE]    = strobe_q;
    data_out[DO_NIBBLE_LSB +: DO_NIBBLE_W] = nibble_q;
  end

  assign data_dir       = {4'b1110, {4{write_dir_q}}};
  assign h_sync         = h_sync_q;
  assign v_sync         = v_sync_q;
  assign frame_start    = frame_start_q;
  assign pixel_out      = (visible && state_q == ST_READ) ? pix_reg_q : '0;
  assign wr_ready       = q_push_rdy;
  assign overflow       = overflow_q;
  assign unused_data_in = ^data_in[7:PIXEL_BITS];

endmodule

// File: tb/tb_vga_fb_streamer.sv
// Directed bench for vga_fb_streamer on a 14x8 frame: continuous timing checks plus a write scoreboard.
module tb_vga_fb_streamer;
  localparam int HT    = 14;
  localparam int VT    = 8;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       h_sync, v_sync, frame_start, wr_ready, overflow;
  logic [3:0] pixel_out;
  logic [7:0] data_dir, data_in, data_out;
  logic       wr_valid, wr_ptr_reset;
  logic [3:0] wr_data;
  logic [2:0] fifo_level;

  logic       h_sync2, v_sync2, frame_start2, wr_ready2, overflow2;
  logic [1:0] pixel_out2;
  logic [7:0] data_dir2, data_out2;
  logic [2:0] fifo_level2;

  vga_fb_streamer #(
    .LINE_VISIBLE(8), .LINE_FRONT_PORCH(2), .LINE_SYNC_PULSE(2), .LINE_BACK_PORCH(2),
    .ROW_VISIBLE(4), .ROW_FRONT_PORCH(1), .ROW_SYNC_PULSE(1), .ROW_BACK_PORCH(2),
    .PIXEL_BITS(4), .SYNC_ACTIVE(1'b1), .FIFO_DEPTH(4), .WAIT_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .h_sync(h_sync), .v_sync(v_sync), .pixel_out(pixel_out),
    .frame_start(frame_start), .data_dir(data_dir), .data_in(data_in), .data_out(data_out),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ptr_reset(wr_ptr_reset), .wr_ready(wr_ready),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  vga_fb_streamer #(
    .LINE_VISIBLE(8), .LINE_FRONT_PORCH(2), .LINE_SYNC_PULSE(2), .LINE_BACK_PORCH(2),
    .ROW_VISIBLE(4), .ROW_FRONT_PORCH(1), .ROW_SYNC_PULSE(1), .ROW_BACK_PORCH(2),
    .PIXEL_BITS(2), .SYNC_ACTIVE(1'b1), .FIFO_DEPTH(4), .WAIT_CYCLES(4)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .h_sync(h_sync2), .v_sync(v_sync2), .pixel_out(pixel_out2),
    .frame_start(frame_start2), .data_dir(data_dir2), .data_in(data_in), .data_out(data_out2),
    .wr_valid(1'b0), .wr_data(2'b00), .wr_ptr_reset(1'b0), .wr_ready(wr_ready2),
    .fifo_level(fifo_level2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference position: pixel/line the DUT should hold after each edge.
  int mp = 0, ml = 0, cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      mp = 0; ml = 0; cyc = 0;
    end else begin
      cyc++;
      if (mp == HT - 1) begin
        mp = 0;
        ml = (ml == VT - 1) ? 0 : ml + 1;
      end else begin
        mp++;
      end
    end
  end

  logic [4:0] exp_q[$];
  int strobe_pos[$];
  int rise_pos[$];
  int last_fs = -1;
  int fs_count = 0;
  bit prev_wb = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_fs = -1;
      prev_wb = 1'b0;
    end else if (cyc >= 1) begin
      check("h_sync", h_sync, (mp >= 10 && mp < 12));
      check("v_sync", v_sync, (ml == 5));
      check("frame_start", frame_start, (mp == 0 && ml == 0));
      check("pixel_out_pb4", pixel_out, (mp < 8 && ml < 4) ? 5 : 0);
      check("pixel_out_pb2", pixel_out2, (mp < 8 && ml < 4) ? 1 : 0);
      check("data_dir", data_dir, 8'hE0);
      if (ml < 4) check("write_bit_visible", data_out[7], 1'b0);
      if (!data_out[7]) check("reset_ptr_read", data_out[6], h_sync);
      if (frame_start) begin
        fs_count++;
        if (last_fs >= 0) check("frame_period", cyc - last_fs, FRAME);
        last_fs = cyc;
      end
      if (data_out[7] && !prev_wb) rise_pos.push_back(ml * HT + mp);
      prev_wb = data_out[7];
      if (data_out[5]) begin
        strobe_pos.push_back(ml * HT + mp);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL strobe_unexpected: strobe at line %0d pixel %0d, required none", ml, mp);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          check("write_entry", {data_out[6], data_out[3:0]}, e);
          check("strobe_write_bit", data_out[7], 1'b1);
        end
      end
    end
  end

  task automatic wait_pos(input int l, input int p);
    int n;
    n = 0;
    @(negedge clk);
    while (!(ml == l && mp == p) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL wait_pos: line %0d pixel %0d not reached, required within 400 cycles", l, p);
    end
  endtask

  task automatic wait_strobes(input int cnt);
    int n;
    n = 0;
    while (strobe_pos.size() < cnt && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL wait_strobes: saw %0d strobes, required %0d", strobe_pos.size(), cnt);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic rp);
    wr_valid = 1'b1;
    wr_data = d;
    wr_ptr_reset = rp;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic clear_logs();
    strobe_pos.delete();
    rise_pos.delete();
  endtask

  initial begin
    wr_valid = 1'b0;
    wr_data = 4'h0;
    wr_ptr_reset = 1'b0;
    data_in = 8'hA5;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_h_sync", h_sync, 1'b0);
    check("rst_v_sync", v_sync, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_pixel_out", pixel_out, 4'h0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_dir", data_dir, 8'hE0);
    check("rst_fifo_level", fifo_level, 3'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b1);
    rst_n = 1'b1;

    // Free run: three frame starts, no write activity.
    repeat (3 * FRAME + 5) @(negedge clk);
    check("free_run_frames", fs_count, 3);
    check("free_run_no_writes", rise_pos.size(), 0);

    // Three writes queued in a visible line drain at line 4.
    clear_logs();
    wait_pos(1, 2);
    exp_q.push_back({1'b0, 4'h3});
    exp_q.push_back({1'b0, 4'h9});
    exp_q.push_back({1'b0, 4'hC});
    push(4'h3, 1'b0);
    push(4'h9, 1'b0);
    push(4'hC, 1'b0);
    check("s3_level_queued", fifo_level, 3'd3);
    wait_strobes(3);
    check("s3_rise_count", rise_pos.size(), 1);
    if (rise_pos.size() >= 1) check("s3_rise_pos", rise_pos[0], 4 * HT + 0);
    if (strobe_pos.size() >= 3) begin
      check("s3_strobe0", strobe_pos[0], 4 * HT + 5);
      check("s3_strobe1", strobe_pos[1], 4 * HT + 7);
      check("s3_strobe2", strobe_pos[2], 4 * HT + 9);
    end
    @(negedge clk);
    check("s3_drained", fifo_level, 3'd0);

    // Fill to depth, then overflow; reset_ptr flag rides only the first entry.
    clear_logs();
    wait_pos(1, 0);
    exp_q.push_back({1'b1, 4'h1});
    exp_q.push_back({1'b0, 4'h2});
    exp_q.push_back({1'b0, 4'h3});
    exp_q.push_back({1'b0, 4'h4});
    push(4'h1, 1'b1);
    push(4'h2, 1'b0);
    push(4'h3, 1'b0);
    push(4'h4, 1'b0);
    check("s4_full_level", fifo_level, 3'd4);
    check("s4_full_ready", wr_ready, 1'b0);
    check("s4_no_overflow_yet", overflow, 1'b0);
    push(4'hF, 1'b0);
    check("s4_overflow", overflow, 1'b1);
    check("s4_level_after_drop", fifo_level, 3'd4);
    wait_strobes(4);
    if (strobe_pos.size() >= 4) begin
      check("s4_strobe0", strobe_pos[0], 4 * HT + 5);
      check("s4_strobe3", strobe_pos[3], 4 * HT + 11);
    end
    @(negedge clk);
    check("s4_overflow_sticky", overflow, 1'b1);
    check("s4_ready_again", wr_ready, 1'b1);

    // Writes entering late in vblank are cut off by the last line and resume next vblank.
    clear_logs();
    wait_pos(6, 9);
    exp_q.push_back({1'b0, 4'h5});
    exp_q.push_back({1'b0, 4'h6});
    push(4'h5, 1'b0);
    push(4'h6, 1'b0);
    wait_pos(7, 13);
    check("s5_write_bit_l7", data_out[7], 1'b0);
    check("s5_level_l7", fifo_level, 3'd2);
    check("s5_rise_count", rise_pos.size(), 1);
    if (rise_pos.size() >= 1) check("s5_rise_pos", rise_pos[0], 6 * HT + 11);
    check("s5_no_strobe", strobe_pos.size(), 0);
    wait_pos(0, 0);
    check("s5_write_bit_l0", data_out[7], 1'b0);
    wait_strobes(2);
    if (strobe_pos.size() >= 2) begin
      check("s5_strobe0", strobe_pos[0], 4 * HT + 5);
      check("s5_strobe1", strobe_pos[1], 4 * HT + 7);
    end
    if (rise_pos.size() >= 2) check("s5_rise_next", rise_pos[1], 4 * HT + 0);

    // Reset while in WR_IDLE drops the queue and returns to reading.
    clear_logs();
    wait_pos(1, 0);
    exp_q.push_back({1'b0, 4'h7});
    exp_q.push_back({1'b0, 4'h8});
    exp_q.push_back({1'b0, 4'h9});
    push(4'h7, 1'b0);
    push(4'h8, 1'b0);
    push(4'h9, 1'b0);
    wait_pos(4, 6);
    check("s6_write_bit_before", data_out[7], 1'b1);
    check("s6_level_before", fifo_level, 3'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check("s6_write_bit_after", data_out[7], 1'b0);
    check("s6_level_after", fifo_level, 3'd0);
    check("s6_overflow_after", overflow, 1'b0);
    check("s6_data_out_after", data_out, 8'h00);
    check("s6_pixel_after", pixel_out, 4'h0);
    exp_q.delete();
    clear_logs();
    rst_n = 1'b1;
    repeat (FRAME + 20) @(negedge clk);
    check("s6_no_strobe", strobe_pos.size(), 0);
    check("s6_no_write_bit", rise_pos.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/vga_fb_streamer.md
VGA_FB_STREAMER -- requirements
Module: vga_fb_streamer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- LINE_VISIBLE, 640, visible pixels per line
- LINE_FRONT_PORCH, 16, pixels
- LINE_SYNC_PULSE, 96, pixels
- LINE_BACK_PORCH, 48, pixels
- ROW_VISIBLE, 480, visible lines
- ROW_FRONT_PORCH, 10, lines
- ROW_SYNC_PULSE, 2, lines
- ROW_BACK_PORCH, 33, lines
- PIXEL_BITS, 4, pixel width; legal values 1, 2, 4
- SYNC_ACTIVE, 1, active level of h_sync/v_sync
- FIFO_DEPTH, 8, write-queue entries; power of 2, 2..16
- WAIT_CYCLES, 16, write-mode entry delay; range 1..16
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock
- rst_n, in, 1, reset: synchronous, active-low
- h_sync, out, 1, horizontal sync
- v_sync, out, 1, vertical sync
- pixel_out, out, PIXEL_BITS, pixel value; blanked outside visible area
- frame_start, out, 1, one-cycle pulse at pixel 0 of line 0
- data_dir, out, 8, QSPI pin direction (1 = output)
- data_in, in, 8, QSPI pins, input
- data_out, out, 8, QSPI pins, output
- wr_valid, in, 1, write request
- wr_data, in, PIXEL_BITS, pixel to write
- wr_ptr_reset, in, 1, queued with wr_data; resets the RAM pointer before this write
- wr_ready, out, 1, queue not full
- fifo_level, out, clog2(FIFO_DEPTH)+1, queue occupancy
- overflow, out, 1, sticky; set by wr_valid while wr_ready=0

Function
REQ-003 Pixel counter shall count 0..H_TOTAL-1 and wrap, where H_TOTAL is the sum of the LINE_* parameters. Line counter shall count 0..V_TOTAL-1 and wrap, where V_TOTAL is the sum of the ROW_* parameters. Line counter shall advance when the pixel counter wraps.
REQ-004 h_sync shall equal SYNC_ACTIVE for pixels [LV+LFP, LV+LFP+LSP). v_sync shall equal SYNC_ACTIVE for lines [RV+RFP, RV+RFP+RSP). Both shall be registered and shall not glitch.
REQ-005 visible = (pixel < LINE_VISIBLE) && (line < ROW_VISIBLE). vblank = (line >= ROW_VISIBLE).
REQ-006 In state READ, the pixel register shall sample data_in[PIXEL_BITS-1:0] every clk. pixel_out shall be the pixel register when visible and state=READ, else 0.
REQ-007 Write queue: the push when wr_valid && wr_ready shall store {wr_ptr_reset, wr_data}. Pop order shall be FIFO. Simultaneous push and pop shall leave fifo_level unchanged. A push while full shall be dropped and shall set overflow.
REQ-008 The FSM shall have states READ, ENTER, WR_IDLE, WR_STROBE.
REQ-009 READ->ENTER when vblank && fifo_level != 0 && line < V_TOTAL-1. On entry: write_bit=1, counter=0.
REQ-010 ENTER shall count WAIT_CYCLES clocks, then go to WR_IDLE with write_dir=0.
REQ-011 WR_IDLE->READ when the queue is empty or line == V_TOTAL-1. On exit: write_bit=0 and write_dir stays 0. This guarantees READ before visible line 0.
REQ-012 WR_IDLE->WR_STROBE on pop when neither exit condition holds. For one cycle: strobe=1, nibble=popped data zero-extended to 4 bits, reset_ptr=popped flag. WR_STROBE->WR_IDLE unconditionally.
REQ-013 Per-write throughput: one pop per 2 clocks.
REQ-014 reset_ptr in READ/ENTER shall equal (h_sync == SYNC_ACTIVE).
REQ-015 data_out = {write_bit, reset_ptr, strobe, 1'b0, nibble}.
REQ-016 data_dir = {4'b1110, {4{write_dir}}}.
REQ-017 frame_start shall be registered and shall coincide with pixel 0, line 0.

Reset
REQ-018 While rst_n=0 at a clk edge, all of the following shall hold:
- counters = 0
- h_sync, v_sync = !SYNC_ACTIVE
- state = READ
- write_bit, write_dir, strobe = 0
- queue empty, overflow = 0
- pixel_out = 0, frame_start = 0
REQ-019 Reset mid-write shall drop queued entries and shall deassert write_bit the following cycle.

Structure
REQ-020 Package vga_fb_pkg shall hold the FSM state encoding, data_out bit-position constants, and H_TOTAL/V_TOTAL helper functions.
REQ-021 The queue shall be a sub-module vga_fb_wr_fifo (parametrised width and depth).
REQ-022 Timing and FSM logic shall stay in vga_fb_streamer.

Verification
REQ-023 Bench timing parameters: LINE 8/2/2/2 (H_TOTAL 14), ROW 4/1/1/2 (V_TOTAL 8), WAIT_CYCLES 4, FIFO_DEPTH 4. Directed scenarios:
- Free run 3 frames -> h_sync active for pixels 10..11 every line; v_sync active on line 5; frame_start every 112 clks.
- data_in=0xA5, PIXEL_BITS=4 -> pixel_out=5 in visible cells, 0 elsewhere; PIXEL_BITS=2 -> pixel_out=1.
- Push 3 entries in a visible line -> writes begin only at line 4; write_bit rises at line 4 pixel 0; first strobe 5 clks later; strobes 2 clks apart; data_out[3:0] matches push order.
- Push 4 entries with the first having wr_ptr_reset=1, then push a 5th -> wr_ready=0; overflow=1; data_out[6]=1 with the first strobe only.
- Queue still non-empty at line 7 -> FSM returns to READ; write_bit=0 before line 0; remaining entries drain in the next vblank.
- Assert rst_n=0 during WR_IDLE -> next cycle write_bit=0, fifo_level=0, state READ.
